// File: rtl/seg_scan_capture.sv
// Seven-segment scan-bus readback: sync, glitch filter, decode to BCD, coherent 8-digit frame commit.
// Latency: pin change -> shadow in STABLE_CYCLES+3 edges, frame commit one edge after the 8th position; no backpressure.
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [7:0]  digit,
  input  logic [7:0]  seg_data,
  input  logic        clr_err,
  output logic [31:0] value,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        err_onehot,
  output logic        err_pattern
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HELD} state_t;

  // The decimal point carries no digit information, so it is never sampled.
  logic unused_dp;
  assign unused_dp = seg_data[0];

  logic [14:0]      sync1_q, sync2_q, prev_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shadow_val_q, shadow_val_d;
  logic [7:0]       shadow_blank_q, shadow_blank_d;
  logic [7:0]       mask_q, mask_d, mask_base;
  logic [31:0]      value_q, value_d;
  logic [7:0]       blank_q, blank_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_pattern_q, err_pattern_d;

  logic             accept;
  logic             pair_changed;
  logic [7:0]       acc_dig;
  logic [6:0]       acc_seg;
  logic             is_onehot;
  logic             is_multi;
  logic [3:0]       dec_nib;
  logic             dec_blank;
  logic             dec_bad;
  logic             commit;

  assign acc_dig      = sync2_q[14:7];
  assign acc_seg      = sync2_q[6:0];
  assign pair_changed = (sync2_q != prev_q);
  assign is_onehot    = (acc_dig != 8'd0) && ((acc_dig & (acc_dig - 8'd1)) == 8'd0);
  assign is_multi     = (acc_dig != 8'd0) && !is_onehot;
  assign commit       = (mask_q == 8'hFF);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pair_changed) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (pair_changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          accept  = 1'b1;
          state_d = S_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (pair_changed) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dec_nib   = 4'hE;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (acc_seg)
      7'h7E: dec_nib = 4'd0;
      7'h30: dec_nib = 4'd1;
      7'h6D: dec_nib = 4'd2;
      7'h79: dec_nib = 4'd3;
      7'h33: dec_nib = 4'd4;
      7'h5B: dec_nib = 4'd5;
      7'h5F: dec_nib = 4'd6;
      7'h70: dec_nib = 4'd7;
      7'h7F: dec_nib = 4'd8;
      7'h7B: dec_nib = 4'd9;
      7'h00: begin
        dec_nib   = 4'hF;
        dec_blank = 1'b1;
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Shadow, mask and mask are kept in digit-bit order: bit j is position 7-j, nibble value[4j+3:4j].
  always_comb begin
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    mask_base      = commit ? 8'd0 : mask_q;
    mask_d         = mask_base;
    if (accept && is_onehot) begin
      for (int j = 0; j < 8; j++) begin
        if (acc_dig[j]) begin
          shadow_val_d[j*4 +: 4] = dec_nib;
          shadow_blank_d[j]      = dec_blank;
        end
      end
      mask_d = ((mask_base & acc_dig) != 8'd0) ? acc_dig : (mask_base | acc_dig);
    end
  end

  always_comb begin
    value_d       = commit ? shadow_val_q : value_q;
    blank_d       = commit ? shadow_blank_q : blank_q;
    frame_valid_d = frame_valid_q | commit;
    frame_done_d  = commit;
    err_onehot_d  = (clr_err ? 1'b0 : err_onehot_q) | (accept & is_multi);
    err_pattern_d = (clr_err ? 1'b0 : err_pattern_q) | (accept & is_onehot & dec_bad);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shadow_val_q   <= '0;
      shadow_blank_q <= '0;
      mask_q         <= '0;
      value_q        <= '0;
      blank_q        <= 8'hFF;
      frame_valid_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      err_onehot_q   <= 1'b0;
      err_pattern_q  <= 1'b0;
    end else begin
      sync1_q        <= {digit, seg_data[7:1]};
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      mask_q         <= mask_d;
      value_q        <= value_d;
      blank_q        <= blank_d;
      frame_valid_q  <= frame_valid_d;
      frame_done_q   <= frame_done_d;
      err_onehot_q   <= err_onehot_d;
      err_pattern_q  <= err_pattern_d;
    end
  end

  assign value       = value_q;
  assign blank_mask  = blank_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign err_onehot  = err_onehot_q;
  assign err_pattern = err_pattern_q;

endmodule
